// File: rtl/id_ctrl_stage.sv
// RV32I decode/control stage: one registered control bundle with valid/ready, load-use interlock and flush.
// Define DECODE_M_EXT_EN to decode the M extension and throttle issue behind the iterative divider.
module id_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5,
  parameter int DIV_LAT    = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
  output logic                  out_op_a_sel,
  output logic                  out_op_b_sel,
  output logic [1:0]            out_wb_sel,
  output logic [1:0]            out_pc_sel,
  output logic                  out_reg_we,
  output logic                  out_mem_we,
  output logic                  out_mem_re,
  output logic [2:0]            out_mem_size,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [XLEN-1:0]       imm;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  op_a_sel;
    logic                  op_b_sel;
    logic [1:0]            wb_sel;
    logic [1:0]            pc_sel;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [2:0]            mem_size;
    logic                  illegal;
  } ctrl_t;

  ctrl_t       dec, bundle_q, bundle_d;
  logic        out_valid_q, out_valid_d;
  logic        legal, uses_rs1, uses_rs2, shamt_imm, writes_rd;
  logic [31:0] imm32;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        hazard, div_busy, in_fire, out_fire;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    shamt_imm = 1'b0;
    writes_rd = 1'b0;
    imm32     = '0;
    case (opcode)
      7'b0110111: begin // lui
        imm32 = {in_inst[31:12], 12'b0};
        dec.wb_sel = 2'b11;
        writes_rd = 1'b1;
      end
      7'b0010111: begin // auipc
        imm32 = {in_inst[31:12], 12'b0};
        dec.op_a_sel = 1'b1;
        writes_rd = 1'b1;
      end
      7'b1101111: begin // jal
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        dec.wb_sel = 2'b01;
        dec.pc_sel = 2'b01;
        writes_rd = 1'b1;
      end
      7'b1100111: begin // jalr
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        uses_rs1 = 1'b1;
        dec.wb_sel = 2'b01;
        dec.pc_sel = 2'b10;
        writes_rd = 1'b1;
        legal = (f3 == 3'b000);
      end
      7'b1100011: begin // branches
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.pc_sel = 2'b11;
        case (f3)
          3'b000:  dec.alu_ctrl = ALU_CTRL_W'(8);
          3'b001:  dec.alu_ctrl = ALU_CTRL_W'(9);
          3'b100:  dec.alu_ctrl = ALU_CTRL_W'(10);
          3'b101:  dec.alu_ctrl = ALU_CTRL_W'(11);
          3'b110:  dec.alu_ctrl = ALU_CTRL_W'(12);
          3'b111:  dec.alu_ctrl = ALU_CTRL_W'(13);
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin // loads
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        uses_rs1 = 1'b1;
        dec.mem_re = 1'b1;
        dec.wb_sel = 2'b10;
        dec.mem_size = f3;
        writes_rd = 1'b1;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
      end
      7'b0100011: begin // stores
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec.mem_we = 1'b1;
        dec.mem_size = f3;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end
      7'b0010011: begin // OP-IMM
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        uses_rs1 = 1'b1;
        writes_rd = 1'b1;
        case (f3)
          3'b000: dec.alu_ctrl = ALU_CTRL_W'(0);
          3'b010: dec.alu_ctrl = ALU_CTRL_W'(14);
          3'b011: dec.alu_ctrl = ALU_CTRL_W'(15);
          3'b100: dec.alu_ctrl = ALU_CTRL_W'(4);
          3'b110: dec.alu_ctrl = ALU_CTRL_W'(3);
          3'b111: dec.alu_ctrl = ALU_CTRL_W'(2);
          3'b001: begin
            shamt_imm = 1'b1;
            dec.alu_ctrl = ALU_CTRL_W'(5);
            legal = (f7 == 7'b0);
          end
          default: begin // srli/srai: bit 30 picks arithmetic, it is not part of the shift amount
            shamt_imm = 1'b1;
            dec.alu_ctrl = in_inst[30] ? ALU_CTRL_W'(7) : ALU_CTRL_W'(6);
            legal = ({in_inst[31], in_inst[29:25]} == 6'b0);
          end
        endcase
      end
      7'b0110011: begin // OP
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec.op_b_sel = 1'b1;
        writes_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alu_ctrl = ALU_CTRL_W'(0);
            3'b001:  dec.alu_ctrl = ALU_CTRL_W'(5);
            3'b010:  dec.alu_ctrl = ALU_CTRL_W'(14);
            3'b011:  dec.alu_ctrl = ALU_CTRL_W'(15);
            3'b100:  dec.alu_ctrl = ALU_CTRL_W'(4);
            3'b101:  dec.alu_ctrl = ALU_CTRL_W'(6);
            3'b110:  dec.alu_ctrl = ALU_CTRL_W'(3);
            default: dec.alu_ctrl = ALU_CTRL_W'(2);
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec.alu_ctrl = ALU_CTRL_W'(1);
            3'b101:  dec.alu_ctrl = ALU_CTRL_W'(7);
            default: legal = 1'b0;
          endcase
`ifdef DECODE_M_EXT_EN
        end else if (f7 == 7'b0000001) begin
          dec.alu_ctrl = ALU_CTRL_W'(5'd16 + {2'b00, f3});
`endif
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    dec.imm    = shamt_imm ? XLEN'(in_inst[24:20]) : XLEN'($signed(imm32));
    dec.rs1    = uses_rs1 ? in_inst[19:15] : 5'd0;
    dec.rs2    = uses_rs2 ? in_inst[24:20] : 5'd0;
    dec.rd     = writes_rd ? in_inst[11:7] : 5'd0;
    dec.reg_we = writes_rd && (in_inst[11:7] != 5'd0);
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
    dec.pc = in_pc;
  end

  // Load-use: the held bundle is a load whose result the incoming instruction reads.
  assign hazard = out_valid_q && bundle_q.mem_re && (bundle_q.rd != 5'd0) && in_valid &&
                  ((uses_rs1 && (in_inst[19:15] == bundle_q.rd)) ||
                   (uses_rs2 && (in_inst[24:20] == bundle_q.rd)));

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (flush) in_ready = 1'b1;
      else       in_ready = (!out_valid_q || out_ready) && !hazard && !div_busy;
    end
  end

  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

`ifdef DECODE_M_EXT_EN
  localparam int CNT_W = $clog2(DIV_LAT);
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_issue;

  assign div_issue = out_fire && (bundle_q.alu_ctrl >= ALU_CTRL_W'(20)) &&
                     (bundle_q.alu_ctrl <= ALU_CTRL_W'(23));
  assign div_busy  = (div_cnt_q != '0);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_busy)  div_cnt_d = div_cnt_q - 1'b1;
    if (div_issue) div_cnt_d = CNT_W'(DIV_LAT - 1);
    if (flush)     div_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end
`else
  logic [31:0] unused_div_lat;
  assign unused_div_lat = 32'(DIV_LAT);
  assign div_busy       = 1'b0;
`endif

  assign out_valid    = out_valid_q;
  assign out_pc       = bundle_q.pc;
  assign out_rs1      = bundle_q.rs1;
  assign out_rs2      = bundle_q.rs2;
  assign out_rd       = bundle_q.rd;
  assign out_imm      = bundle_q.imm;
  assign out_alu_ctrl = bundle_q.alu_ctrl;
  assign out_op_a_sel = bundle_q.op_a_sel;
  assign out_op_b_sel = bundle_q.op_b_sel;
  assign out_wb_sel   = bundle_q.wb_sel;
  assign out_pc_sel   = bundle_q.pc_sel;
  assign out_reg_we   = bundle_q.reg_we;
  assign out_mem_we   = bundle_q.mem_we;
  assign out_mem_re   = bundle_q.mem_re;
  assign out_mem_size = bundle_q.mem_size;
  assign out_illegal  = bundle_q.illegal;

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered decode/control stage for the pipelined RV32I core. It sits between the IF/ID and ID/EX boundaries and decodes one instruction per cycle into a registered control bundle. The stage uses valid/ready handshakes, load-use interlock, flush on redirect, and a sign-extending immediate generator. Optional M-extension decode adds an issue throttle for the non-pipelined divider.

## Interface
- XLEN, 32, datapath/PC/immediate width (32 or 64; encodings are RV32I)
- ALU_CTRL_W, 5, width of `out_alu_ctrl`
- DIV_LAT, 33, cycles the divider is busy after a div/rem issues (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  IF/ID entry valid
- in_ready  out  1  stage accepts entry this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  redirect from EX; kills held and incoming entry
- out_valid  out  1  bundle valid
- out_ready  in  1  EX accepts bundle
- out_pc  out  XLEN  PC of bundle
- out_rs1, out_rs2, out_rd  out  5 each  register indices (0 when unused)
- out_imm  out  XLEN  sign-extended immediate (0 for R-type)
- out_alu_ctrl  out  ALU_CTRL_W  codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 beq, 9 bne, 10 blt, 11 bge, 12 bltu, 13 bgeu, 14 slt, 15 sltu, 16–19 mul/mulh/mulhsu/mulhu, 20–23 div/divu/rem/remu
- out_op_a_sel  out  1  0 = rs1, 1 = pc (auipc)
- out_op_b_sel  out  1  0 = imm, 1 = rs2
- out_wb_sel  out  2  00 alu, 01 pc+4, 10 mem, 11 imm (lui)
- out_pc_sel  out  2  00 seq, 01 jal, 10 jalr, 11 branch
- out_reg_we, out_mem_we, out_mem_re  out  1 each  write enables / load flag
- out_mem_size  out  3  funct3 of load/store
- out_illegal  out  1  undecodable instruction

## Operation
- The stage holds a single output register. Load occurs when `in_valid && in_ready`.
- `in_ready = (!out_valid || out_ready) && !hazard && !div_busy`.
- When `out_valid && out_ready && !in_fire`, `out_valid` clears.
- Decode covers lui, auipc, jal, jalr, branches (6), loads (5), stores (3), OP-IMM (9), and OP (10).
- shamt immediates use bit 30 only to select srai versus srli.
- `reg_we = 0` for branches, stores, illegal instructions, and `rd == 0`.
- Immediates are sign-extended to XLEN per format: I, S, B, U, J. U-type is `inst[31:12] << 12`, sign-extended.
- Illegal instructions (unknown opcode/funct) set `out_illegal = 1` and all write enables to 0. `out_pc_sel` is 00.
- Hazard: `hazard = out_valid && out_mem_re && out_rd != 0 && in_valid && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd))`.
  - The load drains to EX, then exactly one bubble follows.
- div_busy: a counter loads DIV_LAT−1 when a div/divu/rem/remu bundle fires out. It decrements to 0. `div_busy = (cnt != 0)`.
- flush takes priority over all events:
  - next cycle `out_valid = 0` and the div counter is 0;
  - the incoming entry is dropped: `in_ready` is forced 1 during flush so IF discards it.
- Reset: `out_valid = 0`, all out_* fields 0, the div counter 0, and `in_ready = 0` while `rst_n = 0`.

## Timing
- Latency is 1 cycle from in_fire to out_valid. Throughput is 1 per cycle with no hazard.
- `out_*` fields are stable while `out_valid && !out_ready` (hold rule). EX may deassert `out_ready` indefinitely.
- `in_ready` is combinational from `out_ready`, `in_inst`, and state. No combinational path runs from `in_valid` to `out_valid`.
- When a simultaneous drain and fill occur, the new bundle replaces the old one in the same edge.
- A flush asserted during reset is ignored; reset dominates.

## Configuration
- `DECODE_M_EXT_EN` defined:
  - OP with funct7 = 0000001 decodes to ALU codes 16–23;
  - the div_busy counter and DIV_LAT are active.
- `DECODE_M_EXT_EN` undefined:
  - such encodings set `out_illegal = 1` with write enables 0;
  - the counter is not synthesised and `div_busy = 0`.

## Test plan
- Reset with `rst_n = 0` for 2 cycles, then send `0x002081B3` (add x3,x1,x2) → one cycle later `out_valid = 1`, `rs1 = 1`, `rs2 = 2`, `rd = 3`, `alu_ctrl = 0`, `op_b_sel = 1`, `wb_sel = 00`, `reg_we = 1`.
- Send `0xFFF00093` (addi x1,x0,-1) then `0x123450B7` (lui x1,0x12345) → `imm = 0xFFFFFFFF` then `0x12345000`; the lui shows `wb_sel = 11`.
- Send `0x0000A283` (lw x5,0(x1)) then `0x00028333` (add x6,x5,x0) with `out_ready = 1` → `in_ready = 0` for 1 cycle and exactly one out bubble.
  - Then send x0-destination loads → no stall.
- Hold `out_ready = 0` for 3 cycles with a valid bundle → fields unchanged and `in_ready = 0`. Assert flush → `out_valid = 0` the next cycle.
- With the macro defined, issue `0x0220C3B3` (div x7,x1,x2) → `alu_ctrl = 20`, then `in_ready = 0` for DIV_LAT−1 cycles.
  - Without the macro → `out_illegal = 1`, `reg_we = 0`.
